// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM state encoding,
// requester slot indices and the memory_unit function codes.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_ACK   = 2'd3
  } arb_state_t;

  // Requester slots; slot 0 is the tree traversal engine.
  localparam int REQ_TRAVERSAL = 0;
  localparam int REQ_EXECUTE   = 1;
  localparam int REQ_CELL      = 2;
  localparam int REQ_OPER      = 3;

  // memory_unit function codes carried on mem_func.
  localparam logic [1:0] GET_CONTENTS = 2'd0;
  localparam logic [1:0] SET_CONTENTS = 2'd1;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request at or
// after ptr, wrapping modulo N, as both a one-hot vector and an index.
module mem_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  // Scan N candidates starting at ptr; the first hit wins.
  always_comb begin
    int cand;
    cand   = 0;
    valid  = 1'b0;
    onehot = '0;
    idx    = '0;
    for (int off = 0; off < N; off++) begin
      cand = (int'(ptr) + off) % N;
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single memory_unit port among NUM_REQ requesters.
// Round-robin grant with an optional per-owner lock for atomic
// read-modify-write sequences. Optional wait timeout enabled by the
// MEM_ARB_TIMEOUT_EN macro.
//
// Handshake: a requester raises req[i] with its func/addr/wdata stable and
// holds them until ack[i] pulses for one cycle; the transaction is then
// complete and rdata1/rdata2 hold its read data until the next ack. lock[i]
// is sampled in the ack cycle: high keeps the grant for requester i so that
// no one else issues until i finishes a transaction with lock low.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         lock,
  input  logic [NUM_REQ*2-1:0]       req_func,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr1,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr2,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         ack,
  output logic [DATA_W-1:0]          rdata1,
  output logic [DATA_W-1:0]          rdata2,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       mem_execute,
  output logic [ADDR_W-1:0]          address1,
  output logic [ADDR_W-1:0]          address2,
  output logic [1:0]                 mem_func,
  output logic [DATA_W-1:0]          write_data,
  input  logic                       mem_ready,
  input  logic [DATA_W-1:0]          read_data1,
  input  logic [DATA_W-1:0]          read_data2,
  output logic                       timeout_err,
  output arb_state_t                 state_dbg
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t           state;
  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        owner;
  logic                 locked;

  logic                 pick_valid;
  logic [NUM_REQ-1:0]   pick_oh;
  logic [IW-1:0]        pick_idx;

  logic                 sel_go;
  logic [IW-1:0]        sel_idx;
  logic [NUM_REQ-1:0]   sel_oh;
  logic                 keep_lock;
  logic [IW-1:0]        rr_next;

  mem_arbiter_rr_pick #(.N(NUM_REQ), .IW(IW)) u_rr_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .valid  (pick_valid),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

  // A locked owner bypasses the picker and may only issue itself.
  assign sel_go  = locked ? req[owner] : pick_valid;
  assign sel_idx = locked ? owner      : pick_idx;
  assign sel_oh  = locked ? grant      : pick_oh;

  assign rr_next   = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  assign state_dbg = state;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [CW-1:0] wait_cnt;
  logic          timed_out;

  // A timed-out transaction always drops the lock.
  assign keep_lock = lock[owner] & ~timed_out;
`else
  assign keep_lock   = lock[owner];
  assign timeout_err = 1'b0;
`endif

  // Arbitration FSM: pick, issue a one-cycle execute, wait, acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ARB_IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      locked      <= 1'b0;
      grant       <= '0;
      ack         <= '0;
      rdata1      <= '0;
      rdata2      <= '0;
      mem_execute <= 1'b0;
      address1    <= '0;
      address2    <= '0;
      mem_func    <= '0;
      write_data  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      wait_cnt    <= '0;
      timed_out   <= 1'b0;
      timeout_err <= 1'b0;
`endif
    end else begin
      ack <= '0;
      case (state)
        ARB_IDLE: begin
          if (sel_go) begin
            owner       <= sel_idx;
            grant       <= sel_oh;
            mem_func    <= req_func[sel_idx*2 +: 2];
            address1    <= req_addr1[sel_idx*ADDR_W +: ADDR_W];
            address2    <= req_addr2[sel_idx*ADDR_W +: ADDR_W];
            write_data  <= req_wdata[sel_idx*DATA_W +: DATA_W];
            mem_execute <= 1'b1;
            state       <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          // memory_unit expects execute/func/addr1/wdata as a single pulse.
          mem_execute <= 1'b0;
          mem_func    <= '0;
          address1    <= '0;
          write_data  <= '0;
          state       <= ARB_WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
          wait_cnt    <= '0;
`endif
        end
        ARB_WAIT: begin
          if (mem_ready) begin
            rdata1 <= read_data1;
            rdata2 <= read_data2;
            ack    <= grant;
            state  <= ARB_ACK;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            rdata1      <= '0;
            rdata2      <= '0;
            ack         <= grant;
            timeout_err <= 1'b1;
            timed_out   <= 1'b1;
            state       <= ARB_ACK;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        ARB_ACK: begin
          if (keep_lock) begin
            locked <= 1'b1;
          end else begin
            locked <= 1'b0;
            grant  <= '0;
            rr_ptr <= rr_next;
          end
          state <= ARB_IDLE;
`ifdef MEM_ARB_TIMEOUT_EN
          timed_out <= 1'b0;
`endif
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memory_unit responder
// and an in-order scoreboard of {ack one-hot, rdata1, rdata2}.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 64;
  localparam int TO = 8;
  localparam int W  = N + 2 * DW;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        req;
  logic [N-1:0]        lock;
  logic [N*2-1:0]      req_func;
  logic [N*AW-1:0]     req_addr1;
  logic [N*AW-1:0]     req_addr2;
  logic [N*DW-1:0]     req_wdata;
  logic [N-1:0]        ack;
  logic [DW-1:0]       rdata1;
  logic [DW-1:0]       rdata2;
  logic [N-1:0]        grant;
  logic                mem_execute;
  logic [AW-1:0]       address1;
  logic [AW-1:0]       address2;
  logic [1:0]          mem_func;
  logic [DW-1:0]       write_data;
  logic                mem_ready;
  logic [DW-1:0]       read_data1;
  logic [DW-1:0]       read_data2;
  logic                timeout_err;
  arb_state_t          state_dbg;

  int total = 0;
  int bad   = 0;

  logic [W-1:0]  exp_q[$];
  logic [DW-1:0] mem [0:1023];

  // responder controls
  logic          resp_en;
  logic          rand_delay;
  int            resp_delay;
  logic          busy;
  int            cnt;
  logic [AW-1:0] cap_a1;
  logic [AW-1:0] cap_a2;
  logic          prev_exec = 1'b0;

  mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .lock        (lock),
    .req_func    (req_func),
    .req_addr1   (req_addr1),
    .req_addr2   (req_addr2),
    .req_wdata   (req_wdata),
    .ack         (ack),
    .rdata1      (rdata1),
    .rdata2      (rdata2),
    .grant       (grant),
    .mem_execute (mem_execute),
    .address1    (address1),
    .address2    (address2),
    .mem_func    (mem_func),
    .write_data  (write_data),
    .mem_ready   (mem_ready),
    .read_data1  (read_data1),
    .read_data2  (read_data2),
    .timeout_err (timeout_err),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ---------------- memory_unit model ----------------
  // Captures the op on the execute pulse, answers mem_ready for one cycle
  // resp_delay cycles after the execute cycle.
  initial begin
    mem_ready  = 1'b0;
    read_data1 = '0;
    read_data2 = '0;
    busy       = 1'b0;
    cnt        = 0;
    cap_a1     = '0;
    cap_a2     = '0;
    forever begin
      @(negedge clk);
      if (mem_execute && !rst) begin
        busy   = 1'b1;
        cnt    = (rand_delay ? int'($urandom_range(1, 4)) : resp_delay) - 1;
        cap_a1 = address1;
        cap_a2 = address2;
        if (mem_func == SET_CONTENTS) mem[address1] = write_data;
      end
      @(posedge clk);
      #1;
      mem_ready  = 1'b0;
      read_data1 = '0;
      read_data2 = '0;
      if (rst) begin
        busy = 1'b0;
      end else if (busy && resp_en) begin
        if (cnt == 0) begin
          mem_ready  = 1'b1;
          read_data1 = mem[cap_a1];
          read_data2 = mem[cap_a2];
          busy       = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // ---------------- protocol monitor ----------------
  always @(negedge clk) begin
    if (!rst && mem_execute) begin
      chk("exec_single_cycle", {63'd0, prev_exec}, 64'd0);
      chk("grant_onehot_at_exec", {63'd0, $onehot(grant)}, 64'd1);
    end
    if (!rst && ack != '0) chk("ack_is_owner", {60'd0, ack}, {60'd0, grant});
    prev_exec = mem_execute;
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic [1:0] f, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2, input logic [DW-1:0] wd, input logic lk);
    req_func[i*2 +: 2]    = f;
    req_addr1[i*AW +: AW] = a1;
    req_addr2[i*AW +: AW] = a2;
    req_wdata[i*DW +: DW] = wd;
    lock[i]               = lk;
    req[i]                = 1'b1;
  endtask

  // Expected result of requester i's currently driven transaction.
  task automatic push_exp(input int i);
    logic [1:0]    f;
    logic [AW-1:0] a1, a2;
    logic [DW-1:0] wd, d1, d2;
    logic [N-1:0]  oh;
    f  = req_func[i*2 +: 2];
    a1 = req_addr1[i*AW +: AW];
    a2 = req_addr2[i*AW +: AW];
    wd = req_wdata[i*DW +: DW];
    d1 = (f == SET_CONTENTS) ? wd : mem[a1];
    d2 = (f == SET_CONTENTS && a2 == a1) ? wd : mem[a2];
    oh = '0;
    oh[i] = 1'b1;
    exp_q.push_back({oh, d1, d2});
  endtask

  task automatic wait_ack(input int budget, output int n, output int idx);
    logic [W-1:0] e;
    n   = 0;
    idx = -1;
    do begin
      @(negedge clk);
      n++;
    end while (ack == '0 && n < budget);
    if (ack == '0) begin
      chk("ack_wait_budget", 64'd0, 64'd1);
    end else begin
      for (int i = 0; i < N; i++) if (ack[i]) idx = i;
      if (exp_q.size() == 0) begin
        chk("scoreboard_underflow", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_ack", {60'd0, ack}, {60'd0, e[W-1 -: N]});
        chk("sb_rdata1", rdata1, e[2*DW-1 -: DW]);
        chk("sb_rdata2", rdata2, e[DW-1:0]);
      end
    end
  endtask

  task automatic drop_req(input int idx);
    @(posedge clk);
    #1;
    if (idx >= 0) begin
      req[idx]  = 1'b0;
      lock[idx] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    req  = '0;
    lock = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n, idx;
    logic [AW-1:0] sa;
    logic [DW-1:0] sd;

    rst        = 1'b1;
    req        = '0;
    lock       = '0;
    req_func   = '0;
    req_addr1  = '0;
    req_addr2  = '0;
    req_wdata  = '0;
    resp_en    = 1'b1;
    rand_delay = 1'b0;
    resp_delay = 2;
    for (int i = 0; i < 1024; i++) mem[i] = 64'h5A00_0000_0000_0000 + 64'(i) * 64'h0001_0003;
    mem[5] = 64'hABCD;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_grant", {60'd0, grant}, 64'd0);
    chk("rst_ack", {60'd0, ack}, 64'd0);
    chk("rst_exec", {63'd0, mem_execute}, 64'd0);
    chk("rst_addr1", {54'd0, address1}, 64'd0);
    chk("rst_rdata1", rdata1, 64'd0);
    chk("rst_state", {62'd0, state_dbg}, {62'd0, ARB_IDLE});
    chk("rst_timeout_err", {63'd0, timeout_err}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // single GET on requester 0, memory answers 2 cycles after execute
    set_req(REQ_TRAVERSAL, GET_CONTENTS, 10'd5, 10'd6, 64'd0, 1'b0);
    push_exp(REQ_TRAVERSAL);
    @(negedge clk);
    chk("t1_exec_c1", {63'd0, mem_execute}, 64'd1);
    chk("t1_addr1_c1", {54'd0, address1}, 64'd5);
    chk("t1_func_c1", {62'd0, mem_func}, {62'd0, GET_CONTENTS});
    chk("t1_grant_c1", {60'd0, grant}, 64'd1);
    chk("t1_state_c1", {62'd0, state_dbg}, {62'd0, ARB_ISSUE});
    @(negedge clk);
    chk("t1_exec_c2", {63'd0, mem_execute}, 64'd0);
    chk("t1_addr1_c2", {54'd0, address1}, 64'd0);
    @(negedge clk);
    chk("t1_no_ack_c3", {60'd0, ack}, 64'd0);
    wait_ack(1, n, idx);
    chk("t1_rdata1", rdata1, 64'hABCD);
    drop_req(idx);
    @(negedge clk);
    chk("t1_grant_released", {60'd0, grant}, 64'd0);
    chk("t1_rdata1_held", rdata1, 64'hABCD);

    // all four at once, random memory latency: served 0,1,2,3
    do_reset();
    rand_delay = 1'b1;
    for (int i = 0; i < N; i++) begin
      set_req(i, GET_CONTENTS, AW'($urandom_range(0, 1023)), AW'($urandom_range(0, 1023)),
              64'd0, 1'b0);
      push_exp(i);
    end
    for (int k = 0; k < N; k++) begin
      wait_ack(20, n, idx);
      chk("t2_order", 64'(idx), 64'(k));
      drop_req(idx);
    end
    rand_delay = 1'b0;
    resp_delay = 1;

    // locked owner 1 runs two transactions while 2 waits
    do_reset();
    sa = AW'($urandom_range(100, 199));
    sd = {$urandom, $urandom};
    set_req(REQ_EXECUTE, GET_CONTENTS, sa, 10'd300, 64'd0, 1'b1);
    push_exp(REQ_EXECUTE);
    set_req(REQ_CELL, GET_CONTENTS, 10'd301, 10'd302, 64'd0, 1'b0);
    wait_ack(20, n, idx);
    chk("t3_first_owner", 64'(idx), 64'(REQ_EXECUTE));
    drop_req(idx);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t3_hold_grant", {60'd0, grant}, 64'b0010);
      chk("t3_hold_no_exec", {63'd0, mem_execute}, 64'd0);
    end
    set_req(REQ_EXECUTE, SET_CONTENTS, sa, 10'd303, sd, 1'b0);
    push_exp(REQ_EXECUTE);
    push_exp(REQ_CELL);
    wait_ack(20, n, idx);
    chk("t3_second_owner", 64'(idx), 64'(REQ_EXECUTE));
    drop_req(idx);
    wait_ack(20, n, idx);
    chk("t3_then_cell", 64'(idx), 64'(REQ_CELL));
    drop_req(idx);

    // rr_ptr is now 3: 3 and 0 pending -> 3 first, then wrap to 0
    set_req(REQ_OPER, GET_CONTENTS, sa, 10'd7, 64'd0, 1'b0);
    set_req(REQ_TRAVERSAL, GET_CONTENTS, 10'd8, sa, 64'd0, 1'b0);
    push_exp(REQ_OPER);
    push_exp(REQ_TRAVERSAL);
    wait_ack(20, n, idx);
    chk("t4_wrap_first", 64'(idx), 64'(REQ_OPER));
    chk("t4_written_data", rdata1, sd);
    drop_req(idx);
    wait_ack(20, n, idx);
    chk("t4_wrap_second", 64'(idx), 64'(REQ_TRAVERSAL));
    drop_req(idx);

    // reset while waiting for mem_ready
    resp_en = 1'b0;
    @(negedge clk);
    set_req(REQ_TRAVERSAL, GET_CONTENTS, 10'd11, 10'd12, 64'd0, 1'b0);
    repeat (3) @(negedge clk);
    chk("t5_in_wait", {62'd0, state_dbg}, {62'd0, ARB_WAIT});
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    chk("t5_grant", {60'd0, grant}, 64'd0);
    chk("t5_ack", {60'd0, ack}, 64'd0);
    chk("t5_exec", {63'd0, mem_execute}, 64'd0);
    chk("t5_addr2", {54'd0, address2}, 64'd0);
    chk("t5_rdata1", rdata1, 64'd0);
    chk("t5_state", {62'd0, state_dbg}, {62'd0, ARB_IDLE});
    rst        = 1'b0;
    resp_en    = 1'b1;
    resp_delay = 2;
    repeat (3) begin
      @(negedge clk);
      chk("t5_no_ack_after", {60'd0, ack}, 64'd0);
    end
    set_req(REQ_OPER, GET_CONTENTS, 10'd13, 10'd14, 64'd0, 1'b0);
    push_exp(REQ_OPER);
    wait_ack(10, n, idx);
    chk("t5_fresh_owner", 64'(idx), 64'(REQ_OPER));
    drop_req(idx);

`ifdef MEM_ARB_TIMEOUT_EN
    // memory never answers: timeout ack with zero data, sticky error
    resp_en = 1'b0;
    @(negedge clk);
    set_req(REQ_EXECUTE, GET_CONTENTS, 10'd20, 10'd21, 64'd0, 1'b1);
    exp_q.push_back({4'b0010, {(2*DW){1'b0}}});
    wait_ack(TO + 6, n, idx);
    chk("to_latency", 64'(n), 64'(TO + 2));
    chk("to_err_set", {63'd0, timeout_err}, 64'd1);
    drop_req(idx);
    repeat (3) @(negedge clk);
    chk("to_lock_cleared", {60'd0, grant}, 64'd0);
    chk("to_err_sticky", {63'd0, timeout_err}, 64'd1);
    do_reset();
    chk("to_err_cleared", {63'd0, timeout_err}, 64'd0);
    resp_en = 1'b1;
`else
    chk("timeout_err_tied", {63'd0, timeout_err}, 64'd0);
`endif

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
